// File: rtl/fb_port_arbiter_if.sv
// Single-master access channel into the framebuffer port arbiter.
// The master drives the request fields; the arbiter returns grant and read data.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 3
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter for the framebuffer RAM logic port with a full-screen clear engine.
// Define FB_ARB_BORDER_EN to paint edge cells with border_color during a clear.
module fb_port_arbiter #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_start_i,
  input  logic [DATA_W-1:0] clear_color_i,
  input  logic [DATA_W-1:0] border_color_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  fb_port_arbiter_if.slave  m0_io,
  fb_port_arbiter_if.slave  m1_io,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic              ram_write_enabled_o,
  output logic [DATA_W-1:0] ram_write_data_o,
  input  logic [DATA_W-1:0] ram_read_data_i
);

  localparam int unsigned Depth = RD_LAT + 1;
  localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [XW-1:0]     XMax     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     YMax     = YW'(HEIGHT - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic              last_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [Depth-1:0]  pipe_vld_q, pipe_id_q;

  logic              pick0, pick1, gnt_en, gnt0, gnt1, rd_issue, on_edge;
  logic [DATA_W-1:0] cell_color;

  // last_q holds the id of the most recently granted master; the other one wins a tie.
  assign pick0    = m0_io.req & (~m1_io.req | last_q);
  assign pick1    = m1_io.req & ~pick0;
  assign gnt_en   = (state_q == StIdle) & ~clear_start_i & ~rst_i;
  assign gnt0     = gnt_en & pick0;
  assign gnt1     = gnt_en & pick1;
  assign rd_issue = gnt1 ? ~m1_io.we : (gnt0 & ~m0_io.we);

`ifdef FB_ARB_BORDER_EN
  assign on_edge = (x_q == '0) | (x_q == XMax) | (y_q == '0) | (y_q == YMax);
`else
  logic unused_border;
  assign unused_border = ^border_color_i;
  assign on_edge       = 1'b0;
`endif

  assign cell_color = on_edge ? border_color_i : clear_color_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      pipe_vld_q  <= '0;
      pipe_id_q   <= '0;
    end else begin
      done_q        <= 1'b0;
      pipe_vld_q[0] <= rd_issue;
      pipe_id_q[0]  <= gnt1;
      for (int i = 1; i < Depth; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
      unique case (state_q)
        StIdle: begin
          if (clear_start_i) begin
            state_q  <= StClear;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ram_we_q <= 1'b0;
          end else if (gnt0 | gnt1) begin
            ram_addr_q  <= gnt1 ? m1_io.addr  : m0_io.addr;
            ram_we_q    <= gnt1 ? m1_io.we    : m0_io.we;
            ram_wdata_q <= gnt1 ? m1_io.wdata : m0_io.wdata;
            last_q      <= gnt1;
          end else begin
            ram_we_q <= 1'b0;
          end
        end
        StClear: begin
          if (clear_start_i) begin
            // Restart: rewind the sweep without signalling completion.
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ram_we_q <= 1'b0;
          end else begin
            ram_addr_q  <= cnt_q;
            ram_we_q    <= 1'b1;
            ram_wdata_q <= cell_color;
            if (cnt_q == LastAddr) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
              if (x_q == XMax) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_io.gnt    = gnt0;
  assign m1_io.gnt    = gnt1;
  assign m0_io.rvalid = pipe_vld_q[Depth-1] & ~pipe_id_q[Depth-1];
  assign m1_io.rvalid = pipe_vld_q[Depth-1] & pipe_id_q[Depth-1];
  assign m0_io.rdata  = pipe_vld_q[Depth-1] ? ram_read_data_i : '0;
  assign m1_io.rdata  = pipe_vld_q[Depth-1] ? ram_read_data_i : '0;

  assign clear_busy_o        = busy_q;
  assign clear_done_o        = done_q;
  assign ram_address_o       = ram_addr_q;
  assign ram_write_enabled_o = ram_we_q;
  assign ram_write_data_o    = ram_wdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: arbitration, read return, clear engine, reset.
// Includes a behavioural RAM with a two-cycle read latency on the port under test.
module tb_fb_port_arbiter;

  localparam int unsigned W     = 320;
  localparam int unsigned H     = 240;
  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 3;
  localparam int unsigned Cells = W * H;

  typedef struct {
    int         due;
    bit         id;
    logic [2:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_start;
  logic [DW-1:0] clear_color, border_color;
  logic          clear_busy, clear_done;
  logic [AW-1:0] ram_address;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

  fb_port_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .clear_start_i      (clear_start),
    .clear_color_i      (clear_color),
    .border_color_i     (border_color),
    .clear_busy_o       (clear_busy),
    .clear_done_o       (clear_done),
    .m0_io              (m0),
    .m1_io              (m1),
    .ram_address_o      (ram_address),
    .ram_write_enabled_o(ram_we),
    .ram_write_data_o   (ram_wdata),
    .ram_read_data_i    (ram_rdata)
  );

  // RAM port B model with backdoor fill/poke.
  logic [2:0]    mem [Cells];
  logic [2:0]    q1;
  logic          fill_en = 1'b0, bd_en = 1'b0;
  logic [2:0]    fill_val = '0, bd_val = '0;
  logic [AW-1:0] bd_addr = '0;

  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < Cells; i++) mem[i] <= fill_val;
    else if (bd_en) mem[bd_addr] <= bd_val;
    if (ram_we && ram_address < AW'(Cells)) mem[ram_address] <= ram_wdata;
    q1        <= (ram_address < AW'(Cells)) ? mem[ram_address] : 3'd0;
    ram_rdata <= q1;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [34:0] all_outs();
    return {m0.gnt, m1.gnt, m0.rvalid, m1.rvalid, m0.rdata, m1.rdata, clear_busy, clear_done,
            ram_address, ram_we, ram_wdata};
  endfunction

  function automatic logic [2:0] exp_color(input int a);
    int x, y;
    x = a % W;
    y = a / W;
`ifdef FB_ARB_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return border_color;
`endif
    return clear_color;
  endfunction

  task automatic test_reset();
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = '0; m0.wdata = '0;
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = '0; m1.wdata = '0;
    clear_start = 1'b0; clear_color = '0; border_color = '0;
    rst = 1'b1;
    next_cycle();
    sample();
    n_tests++;
    if (all_outs() !== 35'd0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
    if (all_outs() !== 35'd0) n_fail++;
    #2 rst = 1'b0;
    m0.req = 1'b0;
    m1.req = 1'b0;
  endtask

  task automatic test_tie_rr();
    int a0 = 10, a1 = 20, exp_addr = -1;
    bit e0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0.req = 1'b1; m0.we = 1'b1; m0.addr = AW'(a0); m0.wdata = 3'(a0);
      m1.req = 1'b1; m1.we = 1'b1; m1.addr = AW'(a1); m1.wdata = 3'(a1);
      sample();
      e0 = (i % 2 == 0);
      n_tests++;
      if ({m0.gnt, m1.gnt} !== {e0, ~e0}) begin
        n_fail++;
        $display("FAIL tie_gnt[%0d]: got %b expected %b", i, {m0.gnt, m1.gnt}, {e0, ~e0});
      end
      if (exp_addr >= 0) begin
        n_tests++;
        if (ram_address !== AW'(exp_addr) || ram_we !== 1'b1) begin
          n_fail++;
          $display("FAIL tie_ram_addr[%0d]: got %0d/%b expected %0d/1", i, ram_address, ram_we,
                   exp_addr);
        end
      end
      if (e0) begin exp_addr = a0; a0++; end
      else begin exp_addr = a1; a1++; end
    end
    next_cycle();
    m0.req = 1'b0;
    m1.req = 1'b0;
    sample();
    n_tests++;
    if (ram_address !== AW'(exp_addr) || ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_last_addr: got %0d/%b expected %0d/1", ram_address, ram_we, exp_addr);
    end
    next_cycle();
    sample();
    n_tests++;
    if (ram_we !== 1'b0 || ram_address !== AW'(exp_addr)) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d/%b expected %0d/0", ram_address, ram_we, exp_addr);
    end
  endtask

  task automatic test_read_m1();
    next_cycle();
    bd_en = 1'b1; bd_addr = AW'(100); bd_val = 3'b101;
    next_cycle();
    bd_en = 1'b0;
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = AW'(100);
    sample();
    n_tests++;
    if (m1.gnt !== 1'b1 || m0.gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL m1_read_gnt: got %b expected 01", {m0.gnt, m1.gnt});
    end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      m1.req = 1'b0;
      sample();
      n_tests++;
      if (k == 3) begin
        if ({m0.rvalid, m1.rvalid, m1.rdata} !== {2'b01, 3'b101}) begin
          n_fail++;
          $display("FAIL m1_read_return: got %b/%b/%b expected 0/1/101", m0.rvalid, m1.rvalid,
                   m1.rdata);
        end
      end else if ({m0.rvalid, m1.rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL m1_read_quiet[%0d]: got %b expected 00", k, {m0.rvalid, m1.rvalid});
      end
    end
  endtask

  task automatic test_random();
    rd_t        q[$];
    logic [2:0] shadow [64];
    bit         p0 = 0, p1 = 0, last_m = 1, pv = 0, pwe = 0, e0, e1, ev0, ev1;
    bit         w0 = 0, w1 = 0;
    logic [5:0] a0 = '0, a1 = '0;
    logic [2:0] d0 = '0, d1 = '0, pwd = '0, ed;
    logic [5:0] paddr = '0;
    rst = 1'b1; fill_en = 1'b1; fill_val = 3'd0;
    for (int i = 0; i < 64; i++) shadow[i] = 3'd0;
    next_cycle();
    next_cycle();
    fill_en = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 620; c++) begin
      next_cycle();
      if (!p0 && c < 600 && $urandom_range(0, 2) != 0) begin
        a0 = 6'($urandom_range(0, 63)); w0 = 1'($urandom_range(0, 1));
        d0 = 3'($urandom_range(0, 7)); p0 = 1;
      end
      if (!p1 && c < 600 && $urandom_range(0, 2) != 0) begin
        a1 = 6'($urandom_range(0, 63)); w1 = 1'($urandom_range(0, 1));
        d1 = 3'($urandom_range(0, 7)); p1 = 1;
      end
      m0.req = p0; m0.addr = {13'd0, a0}; m0.we = w0; m0.wdata = d0;
      m1.req = p1; m1.addr = {13'd0, a1}; m1.we = w1; m1.wdata = d1;
      sample();
      e0 = p0 && (!p1 || last_m);
      e1 = p1 && !e0;
      n_tests++;
      if ({m0.gnt, m1.gnt} !== {e0, e1}) begin
        n_fail++;
        $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {m0.gnt, m1.gnt}, {e0, e1});
      end
      n_tests++;
      if (pv ? (ram_we !== pwe || ram_address !== {13'd0, paddr} || (pwe && ram_wdata !== pwd))
             : (ram_we !== 1'b0)) begin
        n_fail++;
        $display("FAIL rnd_ram[%0d]: got %0d/%b/%0d expected %0d/%b/%0d (valid %b)", c,
                 ram_address, ram_we, ram_wdata, paddr, pwe, pwd, pv);
      end
      ev0 = 0; ev1 = 0; ed = '0;
      if (q.size() > 0 && q[0].due == c) begin
        ev0 = !q[0].id; ev1 = q[0].id; ed = q[0].data;
        void'(q.pop_front());
      end
      n_tests++;
      if ({m0.rvalid, m1.rvalid, m0.rdata, m1.rdata} !== {ev0, ev1, ed, ed}) begin
        n_fail++;
        $display("FAIL rnd_rd[%0d]: got %b%b/%0d/%0d expected %b%b/%0d", c, m0.rvalid,
                 m1.rvalid, m0.rdata, m1.rdata, ev0, ev1, ed);
      end
      pv = e0 | e1;
      if (e0) begin
        paddr = a0; pwe = w0; pwd = d0; last_m = 0; p0 = 0;
        if (w0) shadow[a0] = d0;
        else q.push_back('{c + 3, 1'b0, shadow[a0]});
      end
      if (e1) begin
        paddr = a1; pwe = w1; pwd = d1; last_m = 1; p1 = 0;
        if (w1) shadow[a1] = d1;
        else q.push_back('{c + 3, 1'b1, shadow[a1]});
      end
    end
    m0.req = 1'b0;
    m1.req = 1'b0;
  endtask

  // Assumes clear_start was high in the cycle before the first iteration.
  task automatic run_clear(input int stop_at);
    for (int j = 1; j <= Cells + 1; j++) begin
      next_cycle();
      clear_start = (stop_at != 0 && j == stop_at);
      sample();
      if (stop_at == 0 && j == Cells + 1) begin
        n_tests++;
        if ({clear_busy, clear_done, m0.gnt} !== 3'b011) begin
          n_fail++;
          $display("FAIL clear_end: busy/done/gnt0 got %b expected 011", {clear_busy, clear_done,
                   m0.gnt});
        end
        return;
      end
      n_tests++;
      if ({clear_busy, clear_done, m0.gnt} !== 3'b100) begin
        n_fail++;
        $display("FAIL clear_window[%0d]: busy/done/gnt0 got %b expected 100", j,
                 {clear_busy, clear_done, m0.gnt});
      end
      if (j >= 2) begin
        n_tests++;
        if ({ram_we, ram_address, ram_wdata} !== {1'b1, AW'(j - 2), exp_color(j - 2)}) begin
          n_fail++;
          $display("FAIL clear_write[%0d]: got %b/%0d/%0d expected 1/%0d/%0d", j, ram_we,
                   ram_address, ram_wdata, j - 2, exp_color(j - 2));
        end
      end
      if (stop_at != 0 && j == stop_at) return;
    end
  endtask

  task automatic m0_read(input int addr, input logic [2:0] exp);
    int waited = 0;
    next_cycle();
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = AW'(addr);
    sample();
    while (!m0.gnt && waited < 8) begin
      next_cycle();
      sample();
      waited++;
    end
    n_tests++;
    if (!m0.gnt) begin
      n_fail++;
      $display("FAIL readback_gnt[%0d]: got 0 expected 1", addr);
      m0.req = 1'b0;
      return;
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      m0.req = 1'b0;
      sample();
    end
    n_tests++;
    if ({m0.rvalid, m0.rdata} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL readback[%0d]: got %b/%0d expected 1/%0d", addr, m0.rvalid, m0.rdata, exp);
    end
  endtask

  task automatic test_clear();
    next_cycle();
    fill_en = 1'b1; fill_val = 3'b010;
    clear_color = 3'b000; border_color = 3'b111;
    next_cycle();
    fill_en = 1'b0;
    clear_start = 1'b1;
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = AW'(5);
    sample();
    n_tests++;
    if ({m0.gnt, m1.gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_start_priority: got %b expected 00", {m0.gnt, m1.gnt});
    end
    run_clear(5001);
    run_clear(0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      m0.req = 1'b0;
      sample();
      if (k == 1) begin
        n_tests++;
        if ({clear_busy, clear_done} !== 2'b00) begin
          n_fail++;
          $display("FAIL clear_done_pulse: got %b expected 00", {clear_busy, clear_done});
        end
      end
    end
    n_tests++;
    if ({m0.rvalid, m0.rdata} !== {1'b1, exp_color(5)}) begin
      n_fail++;
      $display("FAIL stalled_read: got %b/%0d expected 1/%0d", m0.rvalid, m0.rdata,
               exp_color(5));
    end
`ifdef FB_ARB_BORDER_EN
    m0_read(0, 3'd7);
    m0_read(321, 3'd0);
    m0_read(319, 3'd7);
    m0_read(76799, 3'd7);
`else
    m0_read(0, 3'd0);
    m0_read(321, 3'd0);
    m0_read(319, 3'd0);
    m0_read(76799, 3'd0);
`endif
  endtask

  task automatic test_reset_mid_clear();
    next_cycle();
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = AW'(1);
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = AW'(2);
    clear_start = 1'b1;
    next_cycle();
    clear_start = 1'b0;
    repeat (50) next_cycle();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (all_outs() !== 35'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", all_outs());
    end
    next_cycle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({m0.gnt, m1.gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_tie: got %b expected 10", {m0.gnt, m1.gnt});
    end
    next_cycle();
    sample();
    n_tests++;
    if ({m0.gnt, m1.gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL post_reset_rr: got %b expected 01", {m0.gnt, m1.gnt});
    end
    m0.req = 1'b0;
    m1.req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      sample();
      n_tests++;
      if ({clear_busy, clear_done} !== 2'b00) begin
        n_fail++;
        $display("FAIL no_done_after_abort[%0d]: got %b expected 00", k,
                 {clear_busy, clear_done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie_rr();
    test_read_m1();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
